// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin line arbiter sharing one word-wide memory port between I-cache and D-cache
module imem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_rd,
  input  logic                  m0_wr,
  input  logic [LINE_WIDTH-1:0] m0_wdata,
  output logic [LINE_WIDTH-1:0] m0_rdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_rd,
  input  logic                  m1_wr,
  input  logic [LINE_WIDTH-1:0] m1_wdata,
  output logic [LINE_WIDTH-1:0] m1_rdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_waitrequest,
  output logic [1:0]            grant
);

  localparam int BEATS  = LINE_WIDTH / MEM_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MEM_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [BEAT_W-1:0]     beat;
  logic                  owner;
  logic                  last_owner;
  logic                  op_wr;
  logic [LINE_WIDTH-1:0] wbuf;

  logic                  req0;
  logic                  req1;
  logic                  pick1;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;

  // Master 1 wins only when alone or when master 0 was served last.
  always_comb begin
    req0      = m0_rd | m0_wr;
    req1      = m1_rd | m1_wr;
    pick1     = req1 & (~req0 | ~last_owner);
    sel_wr    = pick1 ? m1_wr    : m0_wr;
    sel_addr  = pick1 ? m1_addr  : m0_addr;
    sel_wdata = pick1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      beat           <= '0;
      owner          <= 1'b0;
      last_owner     <= 1'b1;
      op_wr          <= 1'b0;
      wbuf           <= '0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      m0_waitrequest <= 1'b1;
      m1_waitrequest <= 1'b1;
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_wdata      <= '0;
      grant          <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner     <= pick1;
            op_wr     <= sel_wr;
            beat      <= '0;
            mem_addr  <= sel_addr & LINE_MASK;
            mem_rd    <= ~sel_wr;
            mem_wr    <= sel_wr;
            mem_wdata <= sel_wdata[LINE_WIDTH-1 -: MEM_WIDTH];
            wbuf      <= sel_wdata << MEM_WIDTH;
            grant     <= pick1 ? 2'b10 : 2'b01;
            state     <= XFER;
          end
        end

        XFER: begin
          if (!mem_waitrequest) begin
            // Beat k lands in the k-th word from the top of the line.
            if (!op_wr) begin
              for (int k = 0; k < BEATS; k++) begin
                if (beat == BEAT_W'(k)) begin
                  if (owner)
                    m1_rdata[LINE_WIDTH-1-k*MEM_WIDTH -: MEM_WIDTH] <= mem_rdata;
                  else
                    m0_rdata[LINE_WIDTH-1-k*MEM_WIDTH -: MEM_WIDTH] <= mem_rdata;
                end
              end
            end
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              last_owner <= owner;
              mem_rd     <= 1'b0;
              mem_wr     <= 1'b0;
              if (owner)
                m1_waitrequest <= 1'b0;
              else
                m0_waitrequest <= 1'b0;
              state <= DONE;
            end else begin
              mem_addr  <= mem_addr + BEAT_BYTES;
              mem_wdata <= wbuf[LINE_WIDTH-1 -: MEM_WIDTH];
              wbuf      <= wbuf << MEM_WIDTH;
            end
          end
        end

        DONE: begin
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          grant          <= 2'b00;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares one word-wide memory port between the instruction cache (master 0, line refills for the fetch path) and the data cache (master 1, refills and write-backs). Each master issues whole-line reads or writes. The block picks one master per transfer with round-robin arbitration. It then sequences the line as BEATS single-word memory accesses, assembles or splits the 128-bit line, and completes the request with a one-cycle waitrequest-low handshake.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 128, cache line width in bits
MEM_WIDTH, 32, memory port data width; BEATS = LINE_WIDTH/MEM_WIDTH, a power of two, 4 by default

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
m0_addr  in  ADDR_WIDTH  master 0 line address; the low log2(LINE_WIDTH/8) bits are ignored
m0_rd  in  1  master 0 line read request
m0_wr  in  1  master 0 line write request
m0_wdata  in  LINE_WIDTH  master 0 write line
m0_rdata  out  LINE_WIDTH  master 0 read line
m0_waitrequest  out  1  low for exactly the completion cycle of a master 0 transfer
m1_addr, m1_rd, m1_wr, m1_wdata, m1_rdata, m1_waitrequest  as for master 0
mem_addr  out  ADDR_WIDTH  beat word address
mem_rd  out  1  beat read
mem_wr  out  1  beat write
mem_wdata  out  MEM_WIDTH  beat write data
mem_rdata  in  MEM_WIDTH  beat read data, valid in a cycle where mem_rd=1 and mem_waitrequest=0
mem_waitrequest  in  1  high stalls the current beat
grant  out  2  one-hot owner during XFER/DONE; 0 in IDLE

Behaviour:
- Clock is clock, reset is reset_n; reset is synchronous and active-low. All state updates occur on posedge clock.
- Reset values:
  - state=IDLE, beat counter=0, last_owner=1 (so master 0 wins the first tie), rdata buffers=0.
  - Outputs under reset: mem_rd=mem_wr=0, grant=0, m0/m1_waitrequest=1, mem_addr=0, mem_wdata=0.
- A master's request = rd|wr. When both rd and wr are asserted, the transfer is a write.
- FSM:
  - IDLE: if any request, latch owner, op, line address (addr with low bits zeroed) and wdata; clear the beat counter; go to XFER.
  - IDLE arbitration: one requester gets the grant. With two requesters, the grant goes to the master that is not last_owner.
  - XFER: mem_rd or mem_wr follows the latched op. mem_addr = line_addr + beat*(MEM_WIDTH/8).
  - XFER beat accept: when mem_waitrequest=0, the beat is accepted. On a read, mem_rdata is stored in the line buffer; the counter increments.
  - XFER exit: after beat BEATS-1 is accepted, update last_owner=owner and go to DONE.
  - XFER stall: while mem_waitrequest=1, mem_addr, mem_wdata, mem_rd and mem_wr hold steady.
  - DONE (1 cycle): owner's waitrequest=0; owner's rdata holds the assembled line; then go to IDLE.
- Beat order: beat 0 is the lowest address and maps to line bits [LINE_WIDTH-1 -: MEM_WIDTH]. Beat k maps to [LINE_WIDTH-1-k*MEM_WIDTH -: MEM_WIDTH]. This matches fetch word0 in the MSBs. Writes use the same mapping for mem_wdata.
- m*_rdata is registered. It updates only on that master's read beats and holds otherwise, including after DONE.
- m*_waitrequest is 1 in every cycle except the owner's DONE cycle, whether or not the master is requesting.
- Latency: request seen in IDLE at cycle 0 → beats in cycles 1..BEATS with no stalls → DONE in cycle BEATS+1, which is 5 for the defaults. Each stall cycle adds 1.
- A master must hold its request until waitrequest=0. If a master drops its request mid-transfer, the transfer still completes and the DONE is harmless. Addr and wdata changes after latching are ignored.
- DONE→IDLE costs one cycle, so the minimum gap between transfers is 1 idle cycle. Re-arbitration in that IDLE cycle sees the updated last_owner.
- Reset asserted mid-transfer: the next edge gives IDLE with all reset values. The partial line is discarded and mem_rd/mem_wr drop the cycle after the reset edge.
- No request in IDLE → remain in IDLE with all memory strobes low.

Test Plan:
1. m0_rd addr 0x1004, mem_waitrequest=0, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 → mem_addr sequence 0x1000/04/08/0C; m0_waitrequest=0 only in cycle 5; m0_rdata=0x11111111_22222222_33333333_44444444; grant=01 in cycles 1–5.
2. m0_rd and m1_rd both asserted and held from reset → m0 is served first, then m1 after one IDLE cycle. Re-requesting both afterwards alternates m0, m1, m0.
3. m1_wr addr 0x200C, wdata 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD → mem_wr beats at 0x2000..0x200C carry data AAAA.., BBBB.., CCCC.., DDDD.. in that order; m1_rdata is unchanged.
4. Read with mem_waitrequest=1 for 2 cycles on beat 2 → mem_addr holds 0x1008 for 3 cycles; DONE moves to cycle 7.
5. reset_n=0 for one cycle during beat 2 of an m1 read → next cycle: IDLE, mem_rd=0, grant=0, both waitrequest=1. A following simultaneous m0/m1 request grants m0.
6. m0_rd=m0_wr=1 → a write is performed (mem_wr pulses, mem_rd stays 0) and m0_rdata is unchanged.
